spi_xfer_sequencer: RTL and testbench
=====================================

Name: spi_xfer_sequencer

Overview:
- Bus master that sequences the SPI master IP's 4-register interface (CTRL/TXDATA/RXDATA/STATUS) so that no CPU polling is needed.
- Accepts a command (byte count, clock divider) and then streams TX bytes in and RX bytes out over valid/ready handshakes.
- Performs every register write, START, STATUS poll and RXDATA read itself.
- Sits between a DMA/stream client and the SPI master; drives the SPI master's sel/w_en/r_en/offset/wdata and samples its rdata.

Parameters:
- LEN_W, 5, width of cmd_len; maximum burst is 2**LEN_W-1 bytes.
- POLL_GAP, 2, idle cycles between consecutive STATUS reads (0 = back-to-back).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_len  in  LEN_W  bytes to transfer; 0 is legal (no-op).
- cmd_clkdiv  in  8  written to CTRL[15:8].
- tx_valid  in  1  TX byte offered.
- tx_ready  out  1  TX byte accepted.
- tx_data  in  8  TX byte.
- rx_valid  out  1  RX byte available.
- rx_ready  in  1  consumer accepts RX byte.
- rx_data  out  8  RX byte (RXDATA[7:0]).
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at end of a command.
- sel  out  1  SPI master select.
- w_en  out  1  register write strobe.
- r_en  out  1  register read strobe.
- offset  out  2  register index: 0 CTRL, 1 TXDATA, 2 RXDATA, 3 STATUS.
- wdata  out  32  write data.
- rdata  in  32  read data; combinational, valid in the cycle sel&r_en is high.

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE; cmd_ready=1 once in IDLE.
  - sel, w_en, r_en, tx_ready, rx_valid, busy, done all 0.
  - offset, wdata, rx_data, byte counter all 0.
- Bus access rules:
  - Each access is exactly one cycle with sel=1 and exactly one of w_en/r_en high.
  - rdata is registered at the rising edge ending that cycle.
  - wdata is 0 whenever w_en=0.
- CTRL encoding: bit0 EN, bit1 START (self-clearing in the SPI master), bits[15:8] CLKDIV. STATUS bit1 = DONE. Reading RXDATA clears DONE.
- FSM states and transitions:
  - IDLE: on cmd_valid, latch cmd_len/cmd_clkdiv. len=0 goes to FIN; otherwise CFG.
  - CFG: write CTRL = EN | clkdiv<<8, then go to GET_TX.
  - GET_TX: tx_ready=1. On tx_valid & tx_ready, latch tx_data and go to WR_TX. Waits indefinitely otherwise.
  - WR_TX: write TXDATA = {24'b0, byte}.
  - START: write CTRL = EN | START | clkdiv<<8.
  - POLL: read STATUS. If DONE=1 go to RD_RX; else wait POLL_GAP idle cycles and re-read.
  - RD_RX: read RXDATA, register rdata[7:0] into rx_data.
  - PUSH_RX: rx_valid=1, held stable until rx_ready. On the handshake, decrement the counter: nonzero goes to GET_TX, zero goes to FIN.
  - FIN: write CTRL = 0 (disable), pulse done for that cycle, return to IDLE.
- Latency:
  - Minimum per byte with tx_valid and rx_ready held high and DONE seen on the first poll: GET_TX, WR_TX, START, POLL, RD_RX, PUSH_RX = 6 cycles of overhead plus the SPI shift time.
  - Command overhead: CFG + FIN = 2 cycles.
- Command, TX and RX rules:
  - cmd_* is ignored while busy.
  - tx_ready is never high outside GET_TX.
  - rx_valid is never dropped without rx_ready.
- Reset mid-operation: all outputs return to reset values immediately; the SPI master is left to its own reset, with no cleanup writes.

Optional Feature:
- SPI_SEQ_TIMEOUT_EN defined:
  - Adds a 16-bit poll watchdog, cleared on entry to POLL.
  - If 4096 cycles pass with DONE still 0, the block writes CTRL=0 and returns to IDLE.
  - It pulses done together with a new output port err (1 bit, reset 0, one-cycle pulse); remaining bytes are abandoned.
- Undefined: no err port; POLL waits forever.

Test Plan:
- Reset: rst=0 mid-CFG write → sel/w_en drop to 0 asynchronously, busy=0; after release, cmd_ready=1.
- Single byte, loopback model, cmd_len=1, clkdiv=4, tx 0xA5 → bus sequence in order:
  - CTRL=0x0401, TXDATA=0xA5, CTRL=0x0403;
  - STATUS polls until DONE, then RXDATA read;
  - rx_data=0xA5, then CTRL=0, done pulse.
- Burst: cmd_len=3, tx 0x01,0x80,0xFF with rx_ready=1 → rx stream 0x01,0x80,0xFF, exactly one done pulse, busy low the cycle after FIN.
- Backpressure: rx_ready=0 for 10 cycles in PUSH_RX → rx_valid and rx_data stable, no bus activity, no tx_ready; resumes on rx_ready=1.
- Zero length and busy rules:
  - cmd_len=0 → only a CTRL=0 write plus done; no TXDATA access.
  - cmd_valid pulsed while busy → ignored.
- SPI_SEQ_TIMEOUT_EN with DONE stuck at 0 → err and done pulse 4096 cycles after POLL entry, CTRL=0 written, state IDLE.

Source files
------------

// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: drives the SPI master's CTRL/TXDATA/RXDATA/STATUS
// registers so that a stream client can run multi-byte transfers without
// CPU polling. A command (length, clock divider) is taken in IDLE. Each byte
// is then handled in turn: take a TX byte, write it, START, poll STATUS.DONE,
// read RXDATA and hand the byte to the RX consumer.
// Optional build macro SPI_SEQ_TIMEOUT_EN adds a STATUS-poll watchdog and an
// err output. With the watchdog, a poll that never sees DONE ends the command.
module spi_xfer_sequencer #(
  parameter int LEN_W    = 5,
  parameter int POLL_GAP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       cmd_clkdiv,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [7:0]       tx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [7:0]       rx_data,
  output logic             busy,
  output logic             done,
`ifdef SPI_SEQ_TIMEOUT_EN
  output logic             err,
`endif
  output logic             sel,
  output logic             w_en,
  output logic             r_en,
  output logic [1:0]       offset,
  output logic [31:0]      wdata,
  input  logic [31:0]      rdata
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CFG     = 4'd1;
  localparam logic [3:0] S_GET_TX  = 4'd2;
  localparam logic [3:0] S_WR_TX   = 4'd3;
  localparam logic [3:0] S_START   = 4'd4;
  localparam logic [3:0] S_POLL    = 4'd5;
  localparam logic [3:0] S_GAP     = 4'd6;
  localparam logic [3:0] S_RD_RX   = 4'd7;
  localparam logic [3:0] S_PUSH_RX = 4'd8;
  localparam logic [3:0] S_FIN     = 4'd9;

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_TXDATA = 2'd1;
  localparam logic [1:0] R_RXDATA = 2'd2;
  localparam logic [1:0] R_STATUS = 2'd3;

  // Last idle cycle index between two STATUS reads.
  localparam logic [7:0] GAP_LAST = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;
  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [3:0]       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       clkdiv_q, clkdiv_d;
  logic [7:0]       txb_q, txb_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic [7:0]       gap_q, gap_d;
  logic             timeout;
`ifdef SPI_SEQ_TIMEOUT_EN
  logic [15:0]      wdog_q, wdog_d;
  logic             err_q, err_d;
`endif

  // Only the low byte and STATUS.DONE of rdata are meaningful here.
  logic unused_rdata;
  assign unused_rdata = ^rdata[31:8];

`ifdef SPI_SEQ_TIMEOUT_EN
  // The watchdog is 0 on the first POLL cycle, so reaching 4095 means the
  // next cycle is the 4096th since POLL entry.
  assign timeout = (wdog_q == 16'd4095);
`else
  assign timeout = 1'b0;
`endif

  // Next-state and datapath-register logic for the sequencer FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clkdiv_d  = clkdiv_q;
    txb_d     = txb_q;
    rx_data_d = rx_data_q;
    gap_d     = gap_q;
`ifdef SPI_SEQ_TIMEOUT_EN
    wdog_d    = wdog_q;
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cnt_d    = cmd_len;
          clkdiv_d = cmd_clkdiv;
          state_d  = (cmd_len == '0) ? S_FIN : S_CFG;
`ifdef SPI_SEQ_TIMEOUT_EN
          err_d    = 1'b0;
`endif
        end
      end
      S_CFG:   state_d = S_GET_TX;
      S_GET_TX: begin
        if (tx_valid) begin
          txb_d   = tx_data;
          state_d = S_WR_TX;
        end
      end
      S_WR_TX: state_d = S_START;
      S_START: begin
        state_d = S_POLL;
`ifdef SPI_SEQ_TIMEOUT_EN
        wdog_d  = 16'd0;
`endif
      end
      S_POLL: begin
`ifdef SPI_SEQ_TIMEOUT_EN
        wdog_d = wdog_q + 16'd1;
`endif
        if (rdata[1]) begin
          state_d = S_RD_RX;
        end else if (timeout) begin
          state_d = S_FIN;
`ifdef SPI_SEQ_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end else if (POLL_GAP > 0) begin
          gap_d   = 8'd0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
`ifdef SPI_SEQ_TIMEOUT_EN
        wdog_d = wdog_q + 16'd1;
`endif
        if (timeout) begin
          state_d = S_FIN;
`ifdef SPI_SEQ_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end else if (gap_q == GAP_LAST) begin
          state_d = S_POLL;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_RD_RX: begin
        rx_data_d = rdata[7:0];
        state_d   = S_PUSH_RX;
      end
      S_PUSH_RX: begin
        if (rx_ready) begin
          cnt_d   = cnt_q - CNT_ONE;
          state_d = (cnt_q == CNT_ONE) ? S_FIN : S_GET_TX;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; async reset abandons any transfer at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      clkdiv_q  <= 8'd0;
      txb_q     <= 8'd0;
      rx_data_q <= 8'd0;
      gap_q     <= 8'd0;
`ifdef SPI_SEQ_TIMEOUT_EN
      wdog_q    <= 16'd0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clkdiv_q  <= clkdiv_d;
      txb_q     <= txb_d;
      rx_data_q <= rx_data_d;
      gap_q     <= gap_d;
`ifdef SPI_SEQ_TIMEOUT_EN
      wdog_q    <= wdog_d;
      err_q     <= err_d;
`endif
    end
  end

  // Bus strobes and handshakes decode straight from the state register, so
  // every access lasts exactly the one cycle spent in its state.
  always_comb begin
    sel    = 1'b0;
    w_en   = 1'b0;
    r_en   = 1'b0;
    offset = R_CTRL;
    wdata  = 32'd0;
    case (state_q)
      S_CFG: begin
        sel = 1'b1; w_en = 1'b1; offset = R_CTRL;
        wdata = {16'd0, clkdiv_q, 8'h01};
      end
      S_WR_TX: begin
        sel = 1'b1; w_en = 1'b1; offset = R_TXDATA;
        wdata = {24'd0, txb_q};
      end
      S_START: begin
        sel = 1'b1; w_en = 1'b1; offset = R_CTRL;
        wdata = {16'd0, clkdiv_q, 8'h03};
      end
      S_POLL: begin
        sel = 1'b1; r_en = 1'b1; offset = R_STATUS;
      end
      S_RD_RX: begin
        sel = 1'b1; r_en = 1'b1; offset = R_RXDATA;
      end
      S_FIN: begin
        sel = 1'b1; w_en = 1'b1; offset = R_CTRL;
        wdata = 32'd0;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign tx_ready  = (state_q == S_GET_TX);
  assign rx_valid  = (state_q == S_PUSH_RX);
  assign rx_data   = rx_data_q;
  assign done      = (state_q == S_FIN);
`ifdef SPI_SEQ_TIMEOUT_EN
  assign err       = (state_q == S_FIN) & err_q;
`endif

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a loopback SPI master model.
module tb_spi_xfer_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_len = 5'd0;
  logic [7:0]  cmd_clkdiv = 8'd0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  tx_data = 8'd0;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data;
  logic        busy, done, sel, w_en, r_en;
  logic [1:0]  offset;
  logic [31:0] wdata, rdata;
`ifdef SPI_SEQ_TIMEOUT_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  spi_xfer_sequencer #(.LEN_W(5), .POLL_GAP(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_clkdiv(cmd_clkdiv),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .busy(busy), .done(done),
`ifdef SPI_SEQ_TIMEOUT_EN
    .err(err),
`endif
    .sel(sel), .w_en(w_en), .r_en(r_en), .offset(offset), .wdata(wdata), .rdata(rdata)
  );

  // Loopback SPI master model: START shifts for 3 cycles, then DONE rises
  // with RXDATA = last TXDATA. Reading RXDATA clears DONE. m_stuck holds
  // DONE low.
  logic [7:0] m_tx = 8'd0, m_rx = 8'd0;
  logic [3:0] m_cnt = 4'd0;
  logic       m_done = 1'b0;
  logic       m_stuck = 1'b0;

  always @(posedge clk) begin
    if (m_cnt != 4'd0) begin
      m_cnt <= m_cnt - 4'd1;
      if (m_cnt == 4'd1 && !m_stuck) begin
        m_done <= 1'b1;
        m_rx   <= m_tx;
      end
    end
    if (sel && w_en && offset == 2'd1) m_tx <= wdata[7:0];
    if (sel && w_en && offset == 2'd0 && wdata[1]) m_cnt <= 4'd3;
    if (sel && r_en && offset == 2'd2) m_done <= 1'b0;
  end

  always_comb begin
    rdata = 32'd0;
    if (offset == 2'd2) rdata = {24'd0, m_rx};
    else if (offset == 2'd3) rdata = {30'd0, m_done, 1'b0};
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int viol = 0;
  int done_cnt = 0;
  logic [34:0] blog[$];
  logic [7:0]  rxlog[$];
  logic [7:0]  tx_vec[8];
  int tx_idx = 0, tx_n = 0;
  logic tx_pend, rx_pend;
  logic [7:0] rx_pend_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: latch what handshakes happen at the coming edge, then at the
  // following negedge advance the TX source and log bus/RX/done activity.
  task automatic tick();
    tx_pend   = tx_valid && tx_ready;
    rx_pend   = rx_valid && rx_ready;
    rx_pend_d = rx_data;
    @(negedge clk);
    cyc++;
    if (tx_pend) begin
      tx_idx++;
      tx_valid = (tx_idx < tx_n);
      tx_data  = (tx_idx < tx_n) ? tx_vec[tx_idx] : 8'd0;
    end
    if (rx_pend) rxlog.push_back(rx_pend_d);
    if (sel) blog.push_back({w_en, offset, w_en ? wdata : 32'd0});
    if (done) done_cnt++;
    if (sel && (w_en == r_en)) viol++;
    if (!sel && (w_en || r_en)) viol++;
    if (!w_en && wdata != 32'd0) viol++;
    if (tx_ready && rx_valid) viol++;
  endtask

  task automatic start_cmd(input int len, input logic [7:0] div, input int n,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    blog.delete(); rxlog.delete(); done_cnt = 0;
    tx_vec[0] = b0; tx_vec[1] = b1; tx_vec[2] = b2;
    tx_idx = 0; tx_n = n;
    tx_valid = (n > 0);
    tx_data  = b0;
    cmd_len = 5'(len); cmd_clkdiv = div; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_until_done(input int maxc);
    int k;
    k = 0;
    while (!done && k < maxc) begin
      tick();
      k++;
    end
    if (!done) chk("done_within_budget", 64'd0, 64'd1);
  endtask

  // Bus log with STATUS reads removed.
  task automatic filt(output logic [34:0] q[$], output int npoll);
    q.delete(); npoll = 0;
    foreach (blog[i]) begin
      if (blog[i][34] == 1'b0 && blog[i][33:32] == 2'd3) npoll++;
      else q.push_back(blog[i]);
    end
  endtask

  logic [34:0] fq[$];
  int npoll;
  logic [7:0] hold_d;
  logic stable;
  int nlog;

  initial begin
    // Reset state
    #1;
    chk("rst_sel", sel, 0);       chk("rst_w_en", w_en, 0);
    chk("rst_r_en", r_en, 0);     chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);     chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0); chk("rst_offset", offset, 0);
    chk("rst_wdata", wdata, 0);   chk("rst_rx_data", rx_data, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Async reset in the middle of the CFG write
    start_cmd(1, 8'h04, 1, 8'hA5, 8'h00, 8'h00);
    chk("cfg_sel", sel, 1); chk("cfg_w_en", w_en, 1); chk("cfg_wdata", wdata, 32'h0401);
    #2 rst = 1'b0;
    #1;
    chk("midrst_sel", sel, 0); chk("midrst_w_en", w_en, 0); chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1; tx_valid = 1'b0; tx_n = 0;
    #1 chk("midrst_cmd_ready", cmd_ready, 1);
    @(negedge clk);

    // Single byte 0xA5, clkdiv 4
    rx_ready = 1'b1;
    start_cmd(1, 8'h04, 1, 8'hA5, 8'h00, 8'h00);
    chk("single_busy", busy, 1); chk("single_cmd_ready", cmd_ready, 0);
    run_until_done(200);
    tick();
    filt(fq, npoll);
    chk("single_nacc", fq.size(), 5);
    if (fq.size() == 5) begin
      chk("single_ctrl_en", fq[0], {1'b1, 2'd0, 32'h0401});
      chk("single_txdata", fq[1], {1'b1, 2'd1, 32'h00A5});
      chk("single_start", fq[2], {1'b1, 2'd0, 32'h0403});
      chk("single_rxread", fq[3], {1'b0, 2'd2, 32'h0});
      chk("single_ctrl_off", fq[4], {1'b1, 2'd0, 32'h0});
    end
    chk("single_polls", npoll, 2);
    chk("single_rx_n", rxlog.size(), 1);
    if (rxlog.size() == 1) chk("single_rx_data", rxlog[0], 8'hA5);
    chk("single_done_cnt", done_cnt, 1);
    chk("single_busy_after", busy, 0);

    // Burst of 3
    start_cmd(3, 8'h10, 3, 8'h01, 8'h80, 8'hFF);
    run_until_done(300);
    tick();
    chk("burst_busy_after", busy, 0);
    chk("burst_rx_n", rxlog.size(), 3);
    if (rxlog.size() == 3) begin
      chk("burst_rx0", rxlog[0], 8'h01);
      chk("burst_rx1", rxlog[1], 8'h80);
      chk("burst_rx2", rxlog[2], 8'hFF);
    end
    chk("burst_tx_taken", tx_idx, 3);
    chk("burst_done_cnt", done_cnt, 1);
    filt(fq, npoll);
    if (fq.size() > 0) chk("burst_first_ctrl", fq[0], {1'b1, 2'd0, 32'h1001});

    // RX backpressure
    rx_ready = 1'b0;
    start_cmd(2, 8'h02, 2, 8'h3C, 8'hC3, 8'h00);
    for (int k = 0; k < 100 && !rx_valid; k++) tick();
    chk("bp_rx_valid_seen", rx_valid, 1);
    hold_d = rx_data;
    nlog = blog.size();
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!rx_valid || rx_data != hold_d || tx_ready || sel) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_no_bus", blog.size(), nlog);
    chk("bp_held_data", hold_d, 8'h3C);
    rx_ready = 1'b1;
    run_until_done(300);
    tick();
    chk("bp_rx_n", rxlog.size(), 2);
    if (rxlog.size() == 2) begin
      chk("bp_rx0", rxlog[0], 8'h3C);
      chk("bp_rx1", rxlog[1], 8'hC3);
    end

    // Zero-length command
    start_cmd(0, 8'h07, 0, 8'h00, 8'h00, 8'h00);
    chk("zero_done", done, 1);
    tick();
    chk("zero_nacc", blog.size(), 1);
    if (blog.size() == 1) chk("zero_ctrl_off", blog[0], {1'b1, 2'd0, 32'h0});
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_busy_after", busy, 0);

    // Command offered while busy is ignored
    start_cmd(1, 8'h04, 1, 8'h5A, 8'h00, 8'h00);
    tick();
    cmd_len = 5'd5; cmd_valid = 1'b1;
    chk("ign_cmd_ready", cmd_ready, 0);
    tick();
    cmd_valid = 1'b0;
    run_until_done(200);
    for (int k = 0; k < 5; k++) tick();
    chk("ign_busy_after", busy, 0);
    chk("ign_done_cnt", done_cnt, 1);
    chk("ign_rx_n", rxlog.size(), 1);
    if (rxlog.size() == 1) chk("ign_rx_data", rxlog[0], 8'h5A);

`ifdef SPI_SEQ_TIMEOUT_EN
    // DONE stuck low: watchdog ends the command
    begin
      int p;
      m_stuck = 1'b1;
      start_cmd(2, 8'h04, 2, 8'h11, 8'h22, 8'h00);
      for (int k = 0; k < 50 && !(sel && r_en && offset == 2'd3); k++) tick();
      p = cyc;
      run_until_done(5000);
      chk("to_latency", cyc - p, 4096);
      chk("to_err", err, 1);
      chk("to_ctrl_off", {w_en, offset, wdata}, {1'b1, 2'd0, 32'h0});
      tick();
      chk("to_err_pulse", err, 0);
      chk("to_busy_after", busy, 0);
      chk("to_rx_n", rxlog.size(), 0);
      m_stuck = 1'b0;
    end
`endif

    chk("bus_protocol", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
